// File: rtl/conv3x3_s2_window_gen.sv
// rtl/conv3x3_s2_window_gen.sv - 3x3 stride-2 sliding window generator over a raster pixel stream
//
// Purpose:
//   Accepts one pixel per In_Valid cycle in raster order and keeps two previous
//   lines in line buffers plus a 3x3 register window. At every even row/even
//   column position with row>=2 and col>=2, the window ending at that pixel is
//   registered onto Win_Out and flagged with Win_Valid one clock later.
//
// Ports:
//   Clk        in   1          clock, rising edge
//   Rst        in   1          asynchronous active-high reset
//   In_Valid   in   1          In_Pixel is valid and accepted this cycle
//   In_Pixel   in   DATA_W     pixel in raster order
//   Win_Valid  out  1          Win_Out holds a fresh stride-2 window
//   Win_Out    out  9*DATA_W   element (r,c) at [DATA_W*(3*r+c) +: DATA_W]; r=0 is the oldest row
//   Frame_Done out  1          one-cycle pulse after the last pixel of a frame is accepted

module conv3x3_s2_window_gen #(
    parameter int IMG_W  = 100,
    parameter int IMG_H  = 100,
    parameter int DATA_W = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  In_Valid,
    input  logic [DATA_W-1:0]     In_Pixel,
    output logic                  Win_Valid,
    output logic [9*DATA_W-1:0]   Win_Out,
    output logic                  Frame_Done
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

    // Position of the next pixel to be accepted
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    // Line buffers addressed by column: lb1 holds the previous row, lb2 the row before it
    logic [DATA_W-1:0] r_lb1 [IMG_W];
    logic [DATA_W-1:0] r_lb2 [IMG_W];

    // 3x3 window, [row][col], row 0 oldest, col 2 newest
    logic [DATA_W-1:0] r_win [3][3];

    logic                r_win_valid;
    logic                r_frame_done;
    logic [9*DATA_W-1:0] r_win_out;

    logic [DATA_W-1:0]   w_lb1_out;
    logic [DATA_W-1:0]   w_lb2_out;
    logic [DATA_W-1:0]   w_win_next [3][3];
    logic [9*DATA_W-1:0] w_win_packed;
    logic                w_col_last;
    logic                w_row_last;
    logic                w_hit;
    logic                w_frame_end;

    // Read-before-write: the read returns the value stored one line (lb1) or two lines (lb2) ago
    assign w_lb1_out = r_lb1[r_col];
    assign w_lb2_out = r_lb2[r_col];

    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);

    // Row/col >= 2 keeps stale data (previous line or previous frame) out of any flagged window
    assign w_hit = In_Valid && (r_row >= ROW_TWO) && (r_col >= COL_TWO)
                   && !r_row[0] && !r_col[0];

    assign w_frame_end = In_Valid && w_col_last && w_row_last;

    // Line buffer storage is deliberately not reset
    always_ff @(posedge Clk) begin
        if (In_Valid) begin
            r_lb1[r_col] <= In_Pixel;
            r_lb2[r_col] <= w_lb1_out;
        end
    end

    // Window after shifting in the current pixel column
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_win_next[r][0] = r_win[r][1];
            w_win_next[r][1] = r_win[r][2];
        end
        w_win_next[0][2] = w_lb2_out;
        w_win_next[1][2] = w_lb1_out;
        w_win_next[2][2] = In_Pixel;
    end

    always_comb begin
        w_win_packed = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w_win_packed[DATA_W*(3*r+c) +: DATA_W] = w_win_next[r][c];
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_win_out    <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else begin
            r_win_valid  <= w_hit;
            r_frame_done <= w_frame_end;

            if (In_Valid) begin
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        r_win[r][c] <= w_win_next[r][c];
                    end
                end

                if (w_col_last) begin
                    r_col <= '0;
                    if (w_row_last) begin
                        r_row <= '0;
                    end else begin
                        r_row <= r_row + ROW_ONE;
                    end
                end else begin
                    r_col <= r_col + COL_ONE;
                end
            end

            // Output holds the last flagged window between hits
            if (w_hit) begin
                r_win_out <= w_win_packed;
            end
        end
    end

    assign Win_Valid  = r_win_valid;
    assign Win_Out    = r_win_out;
    assign Frame_Done = r_frame_done;

endmodule

// File: tb/tb_conv3x3_s2_window_gen.sv
// tb/tb_conv3x3_s2_window_gen.sv - self-checking bench for conv3x3_s2_window_gen

module tb_conv3x3_s2_window_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          b_iv, s_iv;
    logic [15:0]   b_ip, s_ip;
    logic          b_wv, s_wv;
    logic [143:0]  b_wo, s_wo;
    logic          b_fd, s_fd;

    conv3x3_s2_window_gen #(.IMG_W(100), .IMG_H(100), .DATA_W(16)) u_big (
        .Clk(clk), .Rst(rst), .In_Valid(b_iv), .In_Pixel(b_ip),
        .Win_Valid(b_wv), .Win_Out(b_wo), .Frame_Done(b_fd)
    );

    conv3x3_s2_window_gen #(.IMG_W(5), .IMG_H(5), .DATA_W(16)) u_small (
        .Clk(clk), .Rst(rst), .In_Valid(s_iv), .In_Pixel(s_ip),
        .Win_Valid(s_wv), .Win_Out(s_wo), .Frame_Done(s_fd)
    );

    logic         act_wv [2];
    logic         act_fd [2];
    logic [143:0] act_wo [2];
    assign act_wv[0] = b_wv;  assign act_wv[1] = s_wv;
    assign act_fd[0] = b_fd;  assign act_fd[1] = s_fd;
    assign act_wo[0] = b_wo;  assign act_wo[1] = s_wo;

    // Model: image contents and stream position per instance
    int img_w [2] = '{100, 5};
    int img_h [2] = '{100, 5};
    int m_row [2];
    int m_col [2];
    int img [2][100][100];

    logic         e_wv [2];
    logic         e_fd [2];
    logic [143:0] e_wo [2];

    int checks = 0;
    int errors = 0;

    // Statistics gathered from the DUT outputs
    int           n_win [2];
    int           n_fd [2];
    int           fd_with_wv [2];
    int           acc_cnt [2];
    int           first_acc [2];
    logic [143:0] first_wo [2];
    int           last_centre [2];
    int           centres [$];

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [143:0] lit9(input int v [9]);
        logic [143:0] p;
        logic [15:0]  e;
        p = '0;
        for (int i = 0; i < 9; i++) begin
            e = v[i][15:0];
            p[16*i +: 16] = e;
        end
        return p;
    endfunction

    // One clock: drive instance d, update the model's expectation for the next edge
    task automatic step(input int d, input bit v, input logic [15:0] p);
        int R, C;
        logic [15:0] e;
        for (int k = 0; k < 2; k++) begin
            e_wv[k] = 1'b0;
            e_fd[k] = 1'b0;
        end
        if (v) begin
            R = m_row[d];
            C = m_col[d];
            img[d][R][C] = int'(p);
            acc_cnt[d]++;
            if (R >= 2 && C >= 2 && R % 2 == 0 && C % 2 == 0) begin
                e_wv[d] = 1'b1;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++) begin
                        e = img[d][R-2+r][C-2+c][15:0];
                        e_wo[d][16*(3*r+c) +: 16] = e;
                    end
            end
            e_fd[d] = (R == img_h[d]-1) && (C == img_w[d]-1);
            C++;
            if (C == img_w[d]) begin
                C = 0;
                R++;
                if (R == img_h[d]) R = 0;
            end
            m_row[d] = R;
            m_col[d] = C;
        end
        b_iv = (d == 0) && v;
        b_ip = (d == 0) ? p : 16'h0;
        s_iv = (d == 1) && v;
        s_ip = (d == 1) ? p : 16'h0;
        @(negedge clk);
    endtask

    task automatic clear_stats(input int d);
        n_win[d] = 0;
        n_fd[d] = 0;
        fd_with_wv[d] = 0;
        acc_cnt[d] = 0;
        first_acc[d] = -1;
        first_wo[d] = '0;
        last_centre[d] = -1;
        if (d == 1) centres.delete();
    endtask

    task automatic big_frame(input int offset, input bit stalls);
        for (int r = 0; r < 100; r++)
            for (int c = 0; c < 100; c++) begin
                if (stalls)
                    while ($urandom_range(0, 1) == 1) step(0, 1'b0, 16'($urandom));
                step(0, 1'b1, 16'(100*r + c + offset));
            end
    endtask

    // Compare process: checks every cycle, then gathers statistics
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("win_valid[%0d]", d), {143'h0, act_wv[d]}, {143'h0, e_wv[d]});
            chk($sformatf("frame_done[%0d]", d), {143'h0, act_fd[d]}, {143'h0, e_fd[d]});
            chk($sformatf("win_out[%0d]", d), act_wo[d], e_wo[d]);
            if (act_wv[d] === 1'b1) begin
                n_win[d]++;
                if (n_win[d] == 1) begin
                    first_wo[d] = act_wo[d];
                    first_acc[d] = acc_cnt[d];
                end
                last_centre[d] = int'(act_wo[d][64 +: 16]);
                if (d == 1) centres.push_back(int'(act_wo[d][64 +: 16]));
            end
            if (act_fd[d] === 1'b1) begin
                n_fd[d]++;
                if (act_wv[d] === 1'b1) fd_with_wv[d]++;
            end
        end
    end

    initial begin
        int v_first [9] = '{0, 1, 2, 100, 101, 102, 200, 201, 202};
        int v_f2    [9] = '{5000, 5001, 5002, 5100, 5101, 5102, 5200, 5201, 5202};
        int v_cent  [4] = '{6, 8, 16, 18};

        rst = 1'b1;
        b_iv = 1'b0; b_ip = '0; s_iv = 1'b0; s_ip = '0;
        for (int d = 0; d < 2; d++) begin
            m_row[d] = 0; m_col[d] = 0;
            e_wv[d] = 1'b0; e_fd[d] = 1'b0; e_wo[d] = '0;
            clear_stats(d);
        end
        repeat (3) @(negedge clk);
        chk("reset_wv", {143'h0, b_wv}, 144'h0);
        chk("reset_wo", b_wo, 144'h0);
        chk("reset_fd", {143'h0, b_fd}, 144'h0);
        rst = 1'b0;
        @(negedge clk);

        // Continuous frame
        clear_stats(0);
        big_frame(0, 1'b0);
        chk("t1_first_latency", 144'(first_acc[0]), 144'(203));
        chk("t1_first_window", first_wo[0], lit9(v_first));
        chk("t2_count", 144'(n_win[0]), 144'(2401));
        chk("t2_last_centre", 144'(last_centre[0]), 144'(9797));
        chk("t2_frame_done", 144'(n_fd[0]), 144'(1));

        // Random stalls
        clear_stats(0);
        big_frame(0, 1'b1);
        chk("t3_first_window", first_wo[0], lit9(v_first));
        chk("t3_count", 144'(n_win[0]), 144'(2401));
        chk("t3_last_centre", 144'(last_centre[0]), 144'(9797));
        chk("t3_frame_done", 144'(n_fd[0]), 144'(1));

        // Back-to-back frames
        clear_stats(0);
        big_frame(0, 1'b0);
        clear_stats(0);
        big_frame(5000, 1'b0);
        chk("t4_first_window", first_wo[0], lit9(v_f2));
        chk("t4_count", 144'(n_win[0]), 144'(2401));
        chk("t4_last_centre", 144'(last_centre[0]), 144'(14797));

        // Reset mid-frame
        for (int i = 0; i < 5000; i++) step(0, 1'b1, 16'(100*(i/100) + (i%100) + 300));
        rst = 1'b1;
        b_iv = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_row[d] = 0; m_col[d] = 0;
            e_wv[d] = 1'b0; e_fd[d] = 1'b0; e_wo[d] = '0;
        end
        #1;
        chk("t5_rst_wv", {143'h0, b_wv}, 144'h0);
        chk("t5_rst_wo", b_wo, 144'h0);
        chk("t5_rst_fd", {143'h0, b_fd}, 144'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_stats(0);
        big_frame(0, 1'b0);
        chk("t5_first_window", first_wo[0], lit9(v_first));
        chk("t5_count", 144'(n_win[0]), 144'(2401));
        chk("t5_frame_done", 144'(n_fd[0]), 144'(1));

        // Small 5x5 frame
        clear_stats(1);
        for (int p = 0; p < 25; p++) step(1, 1'b1, 16'(p));
        step(1, 1'b0, 16'h0);
        chk("t6_count", 144'(n_win[1]), 144'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < centres.size())
                chk($sformatf("t6_centre%0d", i), 144'(centres[i]), 144'(v_cent[i]));
            else
                chk($sformatf("t6_centre%0d_missing", i), 144'(0), 144'(v_cent[i]));
        end
        chk("t6_frame_done", 144'(n_fd[1]), 144'(1));
        chk("t6_fd_with_valid", 144'(fd_with_wv[1]), 144'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
